// File: rtl/bus_pkg.sv
// Shared definitions for the split-capable bus arbiter.
package bus_pkg;

    localparam int SLAVE_LEN_DEF = 2;

    localparam logic [1:0] SEL_S1      = 2'b00;
    localparam logic [1:0] SEL_S2      = 2'b01;
    localparam logic [1:0] SEL_S3      = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } arb_state_t;

    typedef enum logic {
        MST_1 = 1'b0,
        MST_2 = 1'b1
    } master_t;

    // Split request of the addressed slave; the invalid code never splits.
    function automatic logic split_hit(input logic [2:0] split_en, input logic [1:0] sel);
        logic hit;
        hit = 1'b0;
        case (sel)
            SEL_S1:  hit = split_en[0];
            SEL_S2:  hit = split_en[1];
            SEL_S3:  hit = split_en[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Saturating grant-hold counter; expired flags the last permitted grant cycle.
module hold_timer #(
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] count;

    // Count grant cycles from zero, holding at MAX_HOLD instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    // count is zero in the first grant cycle, so MAX_HOLD-1 marks cycle MAX_HOLD.
    assign expired = (count >= CNT_LAST);

endmodule

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with split-transaction support and grant timeout.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no grant; one cycle to register the winner, next to grant
//   ST_GRANT1 | master 1 owns the bus, held until done/split/timeout
//   ST_GRANT2 | master 2 owns the bus, held until done/split/timeout
module split_arbiter
    import bus_pkg::*;
#(
    parameter int SLAVE_LEN = SLAVE_LEN_DEF,
    parameter int MAX_HOLD  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    input  logic [2:0]           split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic [SLAVE_LEN-1:0] grant_slave_sel,
    output logic                 bus_busy,
    output logic                 arbiter_busy,
    output logic                 timeout
);

    localparam logic [SLAVE_LEN-1:0] SEL_BAD = SLAVE_LEN'(SEL_INVALID);

    arb_state_t             state, next_state;

    logic                   pick_valid;
    master_t                pick_mst;
    logic [SLAVE_LEN-1:0]   pick_sel;
    logic                   pick_resume;

    logic                   resumed;
    master_t                last_mst;

    logic                   split_pending;
    master_t                split_mst;
    logic [SLAVE_LEN-1:0]   split_slave;

    logic                   m1_elig, m2_elig, resumable;
    logic                   arb_req, arb_resume;
    master_t                arb_mst;
    logic [SLAVE_LEN-1:0]   arb_sel;

    logic                   enter_grant, rel_done, rel_split, rel_timeout;
    logic                   hold_expired;
    master_t                cur_mst;

    assign cur_mst      = (state == ST_GRANT2) ? MST_2 : MST_1;
    assign arbiter_busy = split_pending;
    assign timeout      = rel_timeout;

    hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (enter_grant),
        .enable  (state != ST_IDLE),
        .expired (hold_expired)
    );

    // Eligibility: never the invalid code, never the slave locked by a split.
    always_comb begin
        m1_elig   = m1_request && (m1_slave_sel != SEL_BAD) &&
                    !(split_pending && (m1_slave_sel == split_slave));
        m2_elig   = m2_request && (m2_slave_sel != SEL_BAD) &&
                    !(split_pending && (m2_slave_sel == split_slave));
        resumable = split_pending && !split_hit(split_en, split_slave[1:0]) &&
                    ((split_mst == MST_1) ? m1_request : m2_request);
    end

    // Winner selection: resumed split first, then round-robin on a tie.
    always_comb begin
        arb_req    = 1'b0;
        arb_mst    = MST_1;
        arb_sel    = m1_slave_sel;
        arb_resume = 1'b0;
        if (resumable) begin
            arb_req    = 1'b1;
            arb_mst    = split_mst;
            arb_sel    = split_slave;
            arb_resume = 1'b1;
        end else if (m1_elig && m2_elig) begin
            arb_req = 1'b1;
            if (last_mst == MST_1) begin
                arb_mst = MST_2;
                arb_sel = m2_slave_sel;
            end
        end else if (m1_elig) begin
            arb_req = 1'b1;
        end else if (m2_elig) begin
            arb_req = 1'b1;
            arb_mst = MST_2;
            arb_sel = m2_slave_sel;
        end
    end

    // Next state; trans_done beats split, split beats timeout.
    always_comb begin
        next_state  = state;
        enter_grant = 1'b0;
        rel_done    = 1'b0;
        rel_split   = 1'b0;
        rel_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    enter_grant = 1'b1;
                    next_state  = (pick_mst == MST_2) ? ST_GRANT2 : ST_GRANT1;
                end
            end
            ST_GRANT1, ST_GRANT2: begin
                if (trans_done) begin
                    rel_done   = 1'b1;
                    next_state = ST_IDLE;
                end else if (split_hit(split_en, grant_slave_sel[1:0]) && !split_pending) begin
                    rel_split  = 1'b1;
                    next_state = ST_IDLE;
                end else if (hold_expired) begin
                    rel_timeout = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State and registered grant outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            state    <= next_state;
            m1_grant <= (next_state == ST_GRANT1);
            m2_grant <= (next_state == ST_GRANT2);
            bus_busy <= (next_state != ST_IDLE);
        end
    end

    // Requests are sampled only in IDLE, so a request dropped with trans_done is never stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pick_valid  <= 1'b0;
            pick_mst    <= MST_1;
            pick_sel    <= '0;
            pick_resume <= 1'b0;
        end else begin
            pick_valid <= (state == ST_IDLE) && !pick_valid && arb_req;
            if ((state == ST_IDLE) && !pick_valid) begin
                pick_mst    <= arb_mst;
                pick_sel    <= arb_sel;
                pick_resume <= arb_resume;
            end
        end
    end

    // Routed slave, resume marker and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_slave_sel <= '0;
            resumed         <= 1'b0;
            last_mst        <= MST_2;
        end else begin
            if (enter_grant) begin
                grant_slave_sel <= pick_sel;
                resumed         <= pick_resume;
            end
            if (rel_done || rel_split || rel_timeout) begin
                last_mst <= cur_mst;
            end
        end
    end

    // Split record: set on a first split, cleared only when the resumed master completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            split_pending <= 1'b0;
            split_mst     <= MST_1;
            split_slave   <= '0;
        end else if (rel_split) begin
            split_pending <= 1'b1;
            split_mst     <= cur_mst;
            split_slave   <= grant_slave_sel;
        end else if (rel_done && resumed) begin
            split_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_split_arbiter.sv
// Scoreboard bench: each driven cycle queues its expected outputs, popped on the falling edge.
module tb_split_arbiter;

    logic       clk;
    logic       reset;
    logic       m1_request, m2_request;
    logic [1:0] m1_slave_sel, m2_slave_sel;
    logic       trans_done;
    logic [2:0] split_en;
    logic       m1_grant, m2_grant;
    logic [1:0] grant_slave_sel;
    logic       bus_busy, arbiter_busy, timeout;

    typedef struct {
        string      tag;
        logic [6:0] exp;
        logic [6:0] mask;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [6:0] M_ALL  = 7'b1111111;
    localparam logic [6:0] M_NS   = 7'b1100111;
    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_SPL  = 7'b0000010;

    split_arbiter #(
        .SLAVE_LEN (2),
        .MAX_HOLD  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m1_request      (m1_request),
        .m2_request      (m2_request),
        .m1_slave_sel    (m1_slave_sel),
        .m2_slave_sel    (m2_slave_sel),
        .trans_done      (trans_done),
        .split_en        (split_en),
        .m1_grant        (m1_grant),
        .m2_grant        (m2_grant),
        .grant_slave_sel (grant_slave_sel),
        .bus_busy        (bus_busy),
        .arbiter_busy    (arbiter_busy),
        .timeout         (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    function automatic logic [6:0] ex(input logic g1, input logic g2, input logic [1:0] sel,
                                      input logic bb, input logic ab, input logic to);
        return {g1, g2, sel, bb, ab, to};
    endfunction

    function automatic logic [6:0] obs();
        return {m1_grant, m2_grant, grant_slave_sel, bus_busy, arbiter_busy, timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic [1:0] s1, input logic r2,
                         input logic [1:0] s2, input logic td, input logic [2:0] sp);
        m1_request   = r1;
        m1_slave_sel = s1;
        m2_request   = r2;
        m2_slave_sel = s2;
        trans_done   = td;
        split_en     = sp;
    endtask

    // Called at negedge+1: the inputs just driven are sampled by the next rising edge.
    task automatic step(input string tag, input logic [6:0] exp, input logic [6:0] mask);
        sb_entry_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset", 32'(obs()), 32'(E_IDLE));
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            check(e.tag, 32'(obs() & e.mask), 32'(e.exp & e.mask));
        end
    end

    initial begin
        reset = 1'b1;
        do_reset();

        // Tie after reset goes to M1, then alternates.
        drive(1, 2'b00, 1, 2'b00, 0, 3'b000); step("b_pick1",    E_IDLE, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b000); step("b_g1",       ex(1,0,2'b00,1,0,0), M_ALL);
        drive(1, 2'b00, 1, 2'b00, 1, 3'b000); step("b_done1",    E_IDLE, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b000); step("b_pick2",    E_IDLE, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b000); step("b_g2",       ex(0,1,2'b00,1,0,0), M_ALL);
        drive(1, 2'b00, 1, 2'b00, 1, 3'b000); step("b_done2",    E_IDLE, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b000); step("b_pick3",    E_IDLE, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b000); step("b_g1_again", ex(1,0,2'b00,1,0,0), M_ALL);
        drive(0, 2'b00, 0, 2'b00, 1, 3'b000); step("b_done3",    E_IDLE, M_NS);
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("b_idle",     E_IDLE, M_NS);

        // Single request, two-edge latency, request drop ignored while granted.
        drive(1, 2'b01, 0, 2'b00, 0, 3'b000); step("a_pick",  E_IDLE, M_NS);
        drive(0, 2'b01, 0, 2'b00, 0, 3'b000); step("a_grant", ex(1,0,2'b01,1,0,0), M_ALL);
        drive(0, 2'b01, 0, 2'b00, 0, 3'b000); step("a_hold",  ex(1,0,2'b01,1,0,0), M_ALL);
        drive(0, 2'b01, 0, 2'b00, 1, 3'b000); step("a_done",  E_IDLE, M_NS);
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("a_idle",  E_IDLE, M_NS);

        // Split on S1, lockout of S1, other slave served, resume ahead of M2.
        drive(1, 2'b00, 0, 2'b00, 0, 3'b000); step("c_pick",     E_IDLE, M_NS);
        drive(1, 2'b00, 0, 2'b00, 0, 3'b000); step("c_g1",       ex(1,0,2'b00,1,0,0), M_ALL);
        drive(1, 2'b00, 0, 2'b00, 0, 3'b001); step("c_split",    E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b001); step("c_lock1",    E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b001); step("c_lock2",    E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b00, 0, 3'b001); step("c_lock3",    E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b10, 0, 3'b001); step("c_m2_pick",  E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b10, 0, 3'b001); step("c_m2_s3",    ex(0,1,2'b10,1,1,0), M_ALL);
        drive(1, 2'b00, 1, 2'b01, 1, 3'b001); step("c_m2_done",  E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b01, 0, 3'b000); step("c_res_pick", E_SPL, M_NS);
        drive(1, 2'b00, 1, 2'b01, 0, 3'b000); step("c_resume",   ex(1,0,2'b00,1,1,0), M_ALL);
        drive(0, 2'b00, 1, 2'b01, 1, 3'b000); step("c_res_done", E_IDLE, M_NS);
        drive(0, 2'b00, 1, 2'b01, 0, 3'b000); step("c_m2_pick2", E_IDLE, M_NS);
        drive(0, 2'b00, 1, 2'b01, 0, 3'b000); step("c_m2_s2",    ex(0,1,2'b01,1,0,0), M_ALL);
        drive(0, 2'b00, 0, 2'b00, 1, 3'b000); step("c_m2_done2", E_IDLE, M_NS);

        // Timeout on the fourth grant cycle with MAX_HOLD = 4.
        drive(1, 2'b10, 0, 2'b00, 0, 3'b000); step("d_pick",  E_IDLE, M_NS);
        drive(0, 2'b10, 0, 2'b00, 0, 3'b000); step("d_hold1", ex(1,0,2'b10,1,0,0), M_ALL);
        drive(0, 2'b10, 0, 2'b00, 0, 3'b000); step("d_hold2", ex(1,0,2'b10,1,0,0), M_ALL);
        drive(0, 2'b10, 0, 2'b00, 0, 3'b000); step("d_hold3", ex(1,0,2'b10,1,0,0), M_ALL);
        drive(0, 2'b10, 0, 2'b00, 0, 3'b000); step("d_tmo",   ex(1,0,2'b10,1,0,1), M_ALL);
        drive(0, 2'b10, 0, 2'b00, 0, 3'b000); step("d_rel",   E_IDLE, M_NS);
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("d_idle",  E_IDLE, M_NS);

        // trans_done beats a simultaneous split; invalid select never granted.
        drive(1, 2'b00, 0, 2'b00, 0, 3'b000); step("e_pick",    E_IDLE, M_NS);
        drive(1, 2'b00, 0, 2'b00, 0, 3'b000); step("e_g1",      ex(1,0,2'b00,1,0,0), M_ALL);
        drive(0, 2'b00, 0, 2'b00, 1, 3'b001); step("e_td_spl",  E_IDLE, M_NS);
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("e_nosplit", E_IDLE, M_NS);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b00, 1, 2'b11, 0, 3'b000); step("e_inval", E_IDLE, M_NS);
        end
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("e_idle", E_IDLE, M_NS);

        // Reset mid-grant clears every output without waiting for a clock.
        drive(0, 2'b00, 1, 2'b01, 0, 3'b000); step("r_pick",  E_IDLE, M_NS);
        drive(0, 2'b00, 1, 2'b01, 0, 3'b000); step("r_grant", ex(0,1,2'b01,1,0,0), M_ALL);
        drive(0, 2'b00, 0, 2'b01, 0, 3'b000); step("r_hold",  ex(0,1,2'b01,1,0,0), M_ALL);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", 32'(obs()), 32'(E_IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("r_post1", E_IDLE, M_ALL);
        drive(0, 2'b00, 0, 2'b00, 0, 3'b000); step("r_post2", E_IDLE, M_ALL);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
